ftl_burst_ctrl: RTL and testbench

//  Burst front-end for the FTL controller. Accepts a multi-page host request
//  (page-aligned base address, page count, R/W) and splits it into one FTL

---
 rtl/ftl_burst_ctrl_if.sv | 47 ++++
 rtl/ftl_burst_ctrl.sv | 153 +++++++++++++++
 tb/tb_ftl_burst_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ftl_burst_ctrl_if.sv
// Bus bundle for ftl_burst_ctrl: host request, FTL translation, page output and status.
// The slave modport is the burst controller; master is the surrounding host/FTL/sink.
interface ftl_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [LEN_WIDTH-1:0]  req_len_i;
  logic                  req_rw_i;

  logic [ADDR_WIDTH-1:0] mem_address_o;
  logic                  addr_valid_o;
  logic                  mem_rw_o;
  logic [ADDR_WIDTH-1:0] mem_new_address_i;
  logic                  addr_resp_i;
  logic                  cache_hit_i;

  logic                  pg_valid_o;
  logic                  pg_ready_i;
  logic [ADDR_WIDTH-1:0] pg_addr_o;
  logic                  pg_rw_o;
  logic                  pg_hit_o;
  logic                  pg_last_o;

  logic                  busy_o;
  logic                  done_o;
  logic [15:0]           hit_cnt_o;
  logic [15:0]           miss_cnt_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_rw_i,
    input  mem_new_address_i, addr_resp_i, cache_hit_i, pg_ready_i,
    output req_ready_o, mem_address_o, addr_valid_o, mem_rw_o,
    output pg_valid_o, pg_addr_o, pg_rw_o, pg_hit_o, pg_last_o,
    output busy_o, done_o, hit_cnt_o, miss_cnt_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_rw_i,
    output mem_new_address_i, addr_resp_i, cache_hit_i, pg_ready_i,
    input  req_ready_o, mem_address_o, addr_valid_o, mem_rw_o,
    input  pg_valid_o, pg_addr_o, pg_rw_o, pg_hit_o, pg_last_o,
    input  busy_o, done_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/ftl_burst_ctrl.sv
// Burst front-end: splits a multi-page request into one FTL translation per page.
// Define FTL_BURST_LAT_SIM_EN to add the LAT state modelling hit/miss flash latency.
module ftl_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int PAGE_SIZE  = 4096,
  parameter int LEN_WIDTH  = 8,
  parameter int HIT_LAT    = 4,
  parameter int MISS_LAT   = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ftl_burst_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_LAT, S_OUT, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PAGE_INC  = ADDR_WIDTH'(PAGE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ~ADDR_WIDTH'(PAGE_SIZE - 1);

`ifdef FTL_BURST_LAT_SIM_EN
  localparam int LAT_MAX = (HIT_LAT > MISS_LAT) ? HIT_LAT : MISS_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 2);
  logic [LAT_W-1:0]      r_lat;
`endif

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rw;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [ADDR_WIDTH-1:0] r_pg_addr;
  logic                  r_hit;
  logic [15:0]           r_hit_cnt;
  logic [15:0]           r_miss_cnt;

  logic                  w_req_ready;
  logic                  w_addr_valid;
  logic                  w_pg_valid;
  logic                  w_pg_last;
  logic                  w_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_remaining <= '0;
      r_pg_addr   <= '0;
      r_hit       <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
`ifdef FTL_BURST_LAT_SIM_EN
      r_lat       <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_addr      <= bus.req_addr_i & PAGE_MASK;
            r_rw        <= bus.req_rw_i;
            r_remaining <= bus.req_len_i;
          end
        end
        S_WAIT: begin
          if (bus.addr_resp_i) begin
            r_pg_addr <= bus.mem_new_address_i;
            r_hit     <= bus.cache_hit_i;
            if (bus.cache_hit_i) begin
              if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
              if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
`ifdef FTL_BURST_LAT_SIM_EN
            r_lat <= bus.cache_hit_i ? LAT_W'(HIT_LAT) : LAT_W'(MISS_LAT);
`endif
          end
        end
`ifdef FTL_BURST_LAT_SIM_EN
        S_LAT: begin
          if (r_lat != '0) r_lat <= r_lat - 1'b1;
        end
`endif
        S_OUT: begin
          // Address wraps naturally at 2^ADDR_WIDTH.
          if (bus.pg_ready_i && (r_remaining != '0)) begin
            r_remaining <= r_remaining - 1'b1;
            r_addr      <= r_addr + PAGE_INC;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_addr_valid = 1'b0;
    w_pg_valid   = 1'b0;
    w_pg_last    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !rst_i;
        if (bus.req_valid_i) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_addr_valid = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
`ifdef FTL_BURST_LAT_SIM_EN
        if (bus.addr_resp_i) w_state_next = S_LAT;
`else
        if (bus.addr_resp_i) w_state_next = S_OUT;
`endif
      end
`ifdef FTL_BURST_LAT_SIM_EN
      S_LAT: begin
        if (r_lat == '0) w_state_next = S_OUT;
      end
`endif
      S_OUT: begin
        w_pg_valid = 1'b1;
        w_pg_last  = (r_remaining == '0);
        if (bus.pg_ready_i) w_state_next = (r_remaining == '0) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.req_ready_o   = w_req_ready;
  assign bus.addr_valid_o  = w_addr_valid;
  assign bus.mem_address_o = r_addr;
  assign bus.mem_rw_o      = r_rw;
  assign bus.pg_valid_o    = w_pg_valid;
  assign bus.pg_addr_o     = r_pg_addr;
  assign bus.pg_rw_o       = r_rw;
  assign bus.pg_hit_o      = r_hit;
  assign bus.pg_last_o     = w_pg_last;
  assign bus.busy_o        = (r_state != S_IDLE);
  assign bus.done_o        = w_done;
  assign bus.hit_cnt_o     = r_hit_cnt;
  assign bus.miss_cnt_o    = r_miss_cnt;

endmodule

// File: tb/tb_ftl_burst_ctrl.sv
// Randomized self-checking bench for ftl_burst_ctrl with a page-level reference model.
module tb_ftl_burst_ctrl;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int PS = 4096;
  localparam int HL = 4;
  localparam int ML = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ftl_burst_ctrl_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ftl_burst_ctrl #(
    .ADDR_WIDTH(AW), .PAGE_SIZE(PS), .LEN_WIDTH(LW), .HIT_LAT(HL), .MISS_LAT(ML)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hit_m    = 0;
  int miss_m   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_ready"},  bus.req_ready_o,   0);
    check({pfx, "_addr_valid"}, bus.addr_valid_o,  0);
    check({pfx, "_mem_addr"},   bus.mem_address_o, 0);
    check({pfx, "_mem_rw"},     bus.mem_rw_o,      0);
    check({pfx, "_pg_valid"},   bus.pg_valid_o,    0);
    check({pfx, "_pg_addr"},    bus.pg_addr_o,     0);
    check({pfx, "_pg_hit"},     bus.pg_hit_o,      0);
    check({pfx, "_pg_last"},    bus.pg_last_o,     0);
    check({pfx, "_busy"},       bus.busy_o,        0);
    check({pfx, "_done"},       bus.done_o,        0);
    check({pfx, "_hit_cnt"},    bus.hit_cnt_o,     0);
    check({pfx, "_miss_cnt"},   bus.miss_cnt_o,    0);
  endtask

  // One full burst; rnd=0 uses a fixed translation (0x12000 + i pages, miss) and a fixed stall.
  task automatic run_burst(input logic [31:0] addr, input int len, input logic rw,
                           input bit rnd, input int stall);
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [31:0] xl;
    logic        h;
    int          k, d, s, lat;
    base = addr & ~32'(PS - 1);
    check("req_ready", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_len_i   = LW'(len);
    bus.req_rw_i    = rw;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_len_i   = LW'($urandom);
    bus.req_rw_i    = ~rw;
    $display("burst addr=%08h len=%0d rw=%0d", addr, len, rw);
    for (int i = 0; i <= len; i++) begin
      exp_addr = base + 32'(i * PS);
      k = 0;
      while (bus.addr_valid_o !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      check("issue_gap", k, 0);
      check("mem_addr", bus.mem_address_o, exp_addr);
      check("mem_rw", bus.mem_rw_o, rw);
      check("busy", bus.busy_o, 1);
      check("no_ready_busy", bus.req_ready_o, 0);
      d = rnd ? int'($urandom_range(0, 3)) : 0;
      @(negedge clk);
      repeat (d) begin
        check("single_issue", bus.addr_valid_o, 0);
        @(negedge clk);
      end
      check("resp_cycle_addr", bus.mem_address_o, exp_addr);
      check("resp_cycle_issue", bus.addr_valid_o, 0);
      xl = rnd ? 32'($urandom) : 32'h0001_2000 + 32'(i * PS);
      h  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.addr_resp_i       = 1'b1;
      bus.mem_new_address_i = xl;
      bus.cache_hit_i       = h;
      if (h) begin if (hit_m < 65535) hit_m++; end
      else begin if (miss_m < 65535) miss_m++; end
      @(negedge clk);
      bus.addr_resp_i       = 1'b0;
      bus.mem_new_address_i = $urandom;
      bus.cache_hit_i       = 1'($urandom);
`ifdef FTL_BURST_LAT_SIM_EN
      lat = (h ? HL : ML) + 1;
`else
      lat = 0;
`endif
      k = 0;
      while (bus.pg_valid_o !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      check("pg_latency", k, lat);
      s = rnd ? int'($urandom_range(0, 4)) : stall;
      for (int c = 0; c <= s; c++) begin
        check("pg_valid", bus.pg_valid_o, 1);
        check("pg_addr", bus.pg_addr_o, xl);
        check("pg_hit", bus.pg_hit_o, h);
        check("pg_rw", bus.pg_rw_o, rw);
        check("pg_last", bus.pg_last_o, (i == len));
        check("stall_no_issue", bus.addr_valid_o, 0);
        if (c < s) @(negedge clk);
      end
      bus.pg_ready_i = 1'b1;
      @(negedge clk);
      bus.pg_ready_i = 1'b0;
      check("pg_drop", bus.pg_valid_o, 0);
      check("done", bus.done_o, (i == len));
      $display("page %0d addr=%08h xlat=%08h hit=%0d stall=%0d last=%0d",
               i, exp_addr, xl, h, s, (i == len));
    end
    @(negedge clk);
    check("idle_ready", bus.req_ready_o, 1);
    check("idle_busy", bus.busy_o, 0);
    check("hit_cnt", bus.hit_cnt_o, hit_m);
    check("miss_cnt", bus.miss_cnt_o, miss_m);
  endtask

  initial begin
    bus.req_valid_i       = 1'b0;
    bus.req_addr_i        = '0;
    bus.req_len_i         = '0;
    bus.req_rw_i          = 1'b0;
    bus.mem_new_address_i = '0;
    bus.addr_resp_i       = 1'b0;
    bus.cache_hit_i       = 1'b0;
    bus.pg_ready_i        = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    run_burst(32'h0000_5123, 0, 1'b0, 1'b0, 0);
    check("t1_miss_cnt", bus.miss_cnt_o, 1);
    run_burst(32'h0000_8000, 3, 1'b1, 1'b0, 0);
    run_burst(32'h0000_3000, 0, 1'b0, 1'b0, 10);
    run_burst(32'hFFFF_F000, 1, 1'b1, 1'b0, 0);
    for (int b = 0; b < 25; b++)
      run_burst(32'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 1'b1, 0);

    // Abandon a burst while waiting on the FTL, then feed a stray response.
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0004_0000;
    bus.req_len_i   = 8'd2;
    bus.req_rw_i    = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", bus.busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    hit_m  = 0;
    miss_m = 0;
    @(negedge clk);
    bus.addr_resp_i       = 1'b1;
    bus.mem_new_address_i = 32'hDEAD_B000;
    bus.cache_hit_i       = 1'b1;
    @(negedge clk);
    bus.addr_resp_i = 1'b0;
    check("stray_busy", bus.busy_o, 0);
    check("stray_pg_valid", bus.pg_valid_o, 0);
    check("stray_hit_cnt", bus.hit_cnt_o, 0);
    check("stray_pg_addr", bus.pg_addr_o, 0);
    @(negedge clk);
    run_burst(32'h0000_A000, 2, 1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
